// File: rtl/recv2_if.sv
// Signal bundle between a serial line source and the recv2 pair receiver.
// valid/err are single-cycle pulses with no back-pressure; data1/data0 are qualified by valid.
interface recv2_if;
    logic       in;
    logic [7:0] data1;
    logic [7:0] data0;
    logic       valid;
    logic       err;
    logic       busy;
    logic [2:0] state_dbg;

    modport slave (
        input  in,
        output data1, data0, valid, err, busy, state_dbg
    );

    modport master (
        output in,
        input  data1, data0, valid, err, busy, state_dbg
    );
endinterface

// File: rtl/recv2.sv
// Oversampled async serial receiver that assembles two consecutive 8N1 frames
// into one byte pair, with framing and inter-frame timeout error reporting.
module recv2 #(
    parameter int OSR = 16
) (
    input  logic     clk,
    input  logic     rst,
    recv2_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [4:0] CNT_HALF = 5'(OSR / 2 - 1);
    localparam logic [4:0] CNT_FULL = 5'(OSR - 1);
    localparam logic [4:0] CNT_TMO  = 5'(2 * OSR - 1);

    logic       sync1_q, sync2_q, rx_d_q;
    logic       rx, fall;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic       idx_q, idx_d;
    logic [7:0] sreg_q, sreg_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] data1_q, data1_d;
    logic [7:0] data0_q, data0_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    // Synchronizer flops and the edge-detect copy all idle high like the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= bus.in;
            sync2_q <= sync1_q;
            rx_d_q  <= sync2_q;
        end
    end

    assign rx   = sync2_q;
    assign fall = ~rx & rx_d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= 1'b0;
            sreg_q  <= '0;
            hold_q  <= '0;
            data1_q <= '0;
            data0_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
            hold_q  <= hold_d;
            data1_q <= data1_d;
            data0_q <= data0_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;
        hold_d  = hold_q;
        data1_d = data1_q;
        data0_d = data0_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = 1'b0;
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end else begin
                        // Glitch shorter than half a bit: drop silently.
                        state_d = S_IDLE;
                        idx_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    sreg_d = {rx, sreg_q[7:1]};
                    cnt_d  = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (!rx) begin
                        err_d   = 1'b1;
                        idx_d   = 1'b0;
                        state_d = S_IDLE;
                    end else if (!idx_q) begin
                        hold_d  = sreg_q;
                        idx_d   = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        data1_d = hold_q;
                        data0_d = sreg_q;
                        valid_d = 1'b1;
                        idx_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_WAIT: begin
                // A start edge wins over a timeout landing in the same cycle.
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TMO) begin
                    err_d   = 1'b1;
                    idx_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.data1     = data1_q;
    assign bus.data0     = data0_q;
    assign bus.valid     = valid_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.state_dbg = state_q;

endmodule
